// File: rtl/friscv_dmem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// friscv_dmem_responder
//
// Data-memory responder for the core's mem_* load/store interface. Holds a
// word-organised RAM with byte-lane write strobes. It answers every accepted
// request with a single-cycle mem_ready pulse LATENCY cycles after acceptance.
//
// Handshake: mem_en is the request valid. It is sampled only in IDLE. The
// initiator keeps mem_en, mem_wr, mem_addr, mem_wdata and mem_strb stable
// until it samples mem_ready=1. A request is accepted on the first rising edge
// with mem_en=1 in IDLE. A write commits to RAM on that same edge. mem_ready
// is high for exactly one cycle. mem_rdata is valid in that cycle and holds its
// value until the next response.
//
// Ports:
//   aclk, aresetn   clock, asynchronous active-low reset
//   srst            synchronous active-high reset (same effect as aresetn)
//   mem_en          request valid
//   mem_wr          1 = write, 0 = read
//   mem_addr        byte address; bits [1:0] ignored
//   mem_wdata       write data
//   mem_strb        byte-lane write enables (writes only)
//   mem_rdata       read data, valid while mem_ready=1
//   mem_ready       single-cycle completion pulse
//   mem_err         (FRISCV_DMEM_ERR_EN only) out-of-range flag in ready cycle
//
// Optional feature macro: FRISCV_DMEM_ERR_EN. When it is defined, the module
// adds mem_err, and an out-of-range read returns 32'hDEADBEEF instead of 0.
// -----------------------------------------------------------------------------
module friscv_dmem_responder #(
    parameter int ADDRW   = 16,
    parameter int XLEN    = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    input  logic              mem_en,
    input  logic              mem_wr,
    input  logic [ADDRW-1:0]  mem_addr,
    input  logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN/8-1:0] mem_strb,
    output logic [XLEN-1:0]   mem_rdata,
`ifdef FRISCV_DMEM_ERR_EN
    output logic              mem_err,
`endif
    output logic              mem_ready
);

    localparam int NLANE = XLEN / 8;
    localparam int WIDX  = ADDRW - 2;
    localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(LATENCY - 1);

`ifdef FRISCV_DMEM_ERR_EN
    localparam logic [XLEN-1:0] OOR_RDATA = XLEN'(32'hDEADBEEF);
`else
    localparam logic [XLEN-1:0] OOR_RDATA = '0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   cap_q, cap_d;       // word captured by the last read
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              ready_q, ready_d;
`ifdef FRISCV_DMEM_ERR_EN
    logic              oor_q, oor_d;       // latched out-of-range flag
    logic              err_q, err_d;
`endif

    logic [XLEN-1:0]   ram [DEPTH];
    logic [WIDX-1:0]   idx;
    logic [IDXW-1:0]   ram_idx;
    logic              in_range;
    logic              accept;
    logic [XLEN-1:0]   rd_word;
    logic [1:0]        unused_addr_lsb;

    assign idx             = mem_addr[ADDRW-1:2];
    assign ram_idx         = idx[IDXW-1:0];
    assign in_range        = (32'(idx) < DEPTH_U);
    assign unused_addr_lsb = mem_addr[1:0];
    assign rd_word         = in_range ? ram[ram_idx] : OOR_RDATA;

    // Acceptance is also qualified with both resets. This keeps RAM writes
    // consistent with the control state: no write can commit while the
    // block is held in reset.
    assign accept = (state_q == ST_IDLE) && mem_en && !srst && aresetn;

    // The RAM is not reset. Out-of-range writes are dropped so that they
    // never alias onto a low index.
    always_ff @(posedge aclk) begin
        if (accept && mem_wr && in_range) begin
            for (int i = 0; i < NLANE; i++) begin
                if (mem_strb[i]) begin
                    ram[ram_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
`ifdef FRISCV_DMEM_ERR_EN
        oor_d   = oor_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // Writes leave cap_q alone, so their response carries
                    // the last value that was read.
                    if (!mem_wr) begin
                        cap_d = rd_word;
                    end
`ifdef FRISCV_DMEM_ERR_EN
                    oor_d = !in_range;
`endif
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        ready_d = 1'b1;
                        rdata_d = cap_d;
`ifdef FRISCV_DMEM_ERR_EN
                        err_d   = !in_range;
`endif
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                // mem_en is not looked at here. A dropped request still
                // completes.
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    ready_d = 1'b1;
                    rdata_d = cap_q;
`ifdef FRISCV_DMEM_ERR_EN
                    err_d   = oor_q;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (srst) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            cap_d   = '0;
            rdata_d = '0;
            ready_d = 1'b0;
`ifdef FRISCV_DMEM_ERR_EN
            oor_d   = 1'b0;
            err_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            cap_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
`ifdef FRISCV_DMEM_ERR_EN
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
`ifdef FRISCV_DMEM_ERR_EN
            oor_q   <= oor_d;
            err_q   <= err_d;
`endif
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
`ifdef FRISCV_DMEM_ERR_EN
    assign mem_err   = err_q;
`endif

endmodule

// File: tb/tb_friscv_dmem_responder.sv
`timescale 1ns/1ps
// Bench for friscv_dmem_responder. It instantiates three responders with
// LATENCY 1, 3 and 4 on one clock and one pair of resets. Each request pushes
// its expected response, computed from a small RAM model, into a queue. The
// bench pops and compares that entry when mem_ready is seen.
module tb_friscv_dmem_responder;
  localparam int NU    = 3;
  localparam int DEPTH = 1024;
`ifdef FRISCV_DMEM_ERR_EN
  localparam logic [31:0] OOR_VAL = 32'hDEADBEEF;
`else
  localparam logic [31:0] OOR_VAL = 32'h0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        srst = 1'b0;
  logic        mem_en    [NU];
  logic        mem_wr    [NU];
  logic [15:0] mem_addr  [NU];
  logic [31:0] mem_wdata [NU];
  logic [3:0]  mem_strb  [NU];
  logic [31:0] mem_rdata [NU];
  logic        mem_ready [NU];
`ifdef FRISCV_DMEM_ERR_EN
  logic        mem_err   [NU];
`endif

  // clock / reset
  always #5 aclk = ~aclk;

  genvar g;
  generate
    for (g = 0; g < NU; g++) begin : g_dut
      friscv_dmem_responder #(
        .ADDRW(16), .XLEN(32), .DEPTH(DEPTH),
        .LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4))
      ) u_dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .mem_en(mem_en[g]), .mem_wr(mem_wr[g]), .mem_addr(mem_addr[g]),
        .mem_wdata(mem_wdata[g]), .mem_strb(mem_strb[g]),
        .mem_rdata(mem_rdata[g]),
`ifdef FRISCV_DMEM_ERR_EN
        .mem_err(mem_err[g]),
`endif
        .mem_ready(mem_ready[g])
      );
    end
  endgenerate

  // scoreboard state
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  logic [31:0] model_mem [NU][DEPTH];
  logic [31:0] last_rd   [NU];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : ((u == 1) ? 3 : 4);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_last_rd();
    for (int i = 0; i < NU; i++) last_rd[i] = 32'h0;
  endtask

  // Update the model for a request and return its expected response.
  task automatic model_req(input int u, input bit wr, input logic [15:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           output logic [31:0] e, output logic oor);
    int widx;
    widx = int'(addr[15:2]);
    oor  = (widx >= DEPTH);
    if (wr) begin
      if (!oor) begin
        for (int i = 0; i < 4; i++)
          if (strb[i]) model_mem[u][widx][8*i +: 8] = wdata[8*i +: 8];
      end
      e = last_rd[u];
    end else begin
      e = oor ? OOR_VAL : model_mem[u][widx];
      last_rd[u] = e;
    end
  endtask

  // driver: one full request/response transaction
  task automatic do_req(input int u, input bit wr, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] e;
    logic        oor;
    logic        exp_err;
    int          k;
    bit          seen;
    model_req(u, wr, addr, wdata, strb, e, oor);
    exp_q.push_back(e);
    exp_err_q.push_back(oor);
    @(posedge aclk); #1;
    mem_en[u] = 1'b1; mem_wr[u] = wr; mem_addr[u] = addr;
    mem_wdata[u] = wdata; mem_strb[u] = strb;
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(posedge aclk); #1;
      k++;
      if (mem_ready[u]) seen = 1'b1;
    end
    mem_en[u] = 1'b0;
    check_eq($sformatf("u%0d ready_seen @%h", u, addr), 32'(mem_ready[u]), 32'd1);
    check_eq($sformatf("u%0d latency @%h", u, addr), 32'(k), 32'(lat_of(u)));
    e = exp_q.pop_front();
    exp_err = exp_err_q.pop_front();
    check_eq($sformatf("u%0d rdata @%h", u, addr), mem_rdata[u], e);
`ifdef FRISCV_DMEM_ERR_EN
    check_eq($sformatf("u%0d err @%h", u, addr), 32'(mem_err[u]), 32'(exp_err));
`else
    if (exp_err === 1'bx) $display("unexpected X in err queue");
`endif
    @(posedge aclk); #1;
    check_eq($sformatf("u%0d ready_pulse @%h", u, addr), 32'(mem_ready[u]), 32'd0);
    check_eq($sformatf("u%0d rdata_hold @%h", u, addr), mem_rdata[u], e);
`ifdef FRISCV_DMEM_ERR_EN
    check_eq($sformatf("u%0d err_low @%h", u, addr), 32'(mem_err[u]), 32'd0);
`endif
  endtask

  // driver: request interrupted by aresetn n cycles after it was driven
  task automatic req_then_reset(input int u, input bit wr, input logic [15:0] addr,
                                input logic [31:0] wdata, input int n_cyc);
    logic [31:0] e;
    logic        oor;
    int          cnt;
    model_req(u, wr, addr, wdata, 4'hF, e, oor);
    @(posedge aclk); #1;
    mem_en[u] = 1'b1; mem_wr[u] = wr; mem_addr[u] = addr;
    mem_wdata[u] = wdata; mem_strb[u] = 4'hF;
    repeat (n_cyc) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    mem_en[u] = 1'b0;
    #1;
    check_eq($sformatf("u%0d reset_ready", u), 32'(mem_ready[u]), 32'd0);
    check_eq($sformatf("u%0d reset_rdata", u), mem_rdata[u], 32'd0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    clear_last_rd();
    cnt = 0;
    repeat (6) begin
      @(posedge aclk); #1;
      if (mem_ready[u]) cnt++;
    end
    check_eq($sformatf("u%0d no_ready_after_reset", u), 32'(cnt), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [31:0] wd;
    logic [3:0]  st;
    int          u;
    for (int i = 0; i < NU; i++) begin
      mem_en[i] = 1'b0; mem_wr[i] = 1'b0; mem_addr[i] = '0;
      mem_wdata[i] = '0; mem_strb[i] = '0;
    end
    clear_last_rd();

    // reset state
    repeat (3) @(posedge aclk);
    #1;
    for (int i = 0; i < NU; i++) begin
      check_eq($sformatf("u%0d rst_ready", i), 32'(mem_ready[i]), 32'd0);
      check_eq($sformatf("u%0d rst_rdata", i), mem_rdata[i], 32'd0);
    end
    aresetn = 1'b1;

    // LATENCY=1 write then read
    do_req(0, 1'b1, 16'h0010, 32'h12345678, 4'hF);
    do_req(0, 1'b0, 16'h0010, 32'h0, 4'h0);
    check_eq("l1_read_const", mem_rdata[0], 32'h12345678);

    // partial write
    do_req(0, 1'b1, 16'h0020, 32'hFFFFFFFF, 4'hF);
    do_req(0, 1'b1, 16'h0020, 32'h000000AB, 4'b0001);
    do_req(0, 1'b0, 16'h0020, 32'h0, 4'h0);
    check_eq("partial_const", mem_rdata[0], 32'hFFFFFFAB);

    // LATENCY=3
    do_req(1, 1'b1, 16'h0030, 32'hCAFEF00D, 4'hF);
    do_req(1, 1'b0, 16'h0030, 32'h0, 4'h0);

    // out of range: idx 1024 must not alias onto idx 0
    do_req(0, 1'b1, 16'h0000, 32'h0BADC0DE, 4'hF);
    do_req(0, 1'b1, 16'h1000, 32'hFFFFFFFF, 4'hF);
    do_req(0, 1'b0, 16'h1000, 32'h0, 4'h0);
    check_eq("oor_read_const", mem_rdata[0], OOR_VAL);
    do_req(0, 1'b0, 16'h0000, 32'h0, 4'h0);
    do_req(2, 1'b0, 16'hFFFC, 32'h0, 4'h0);

    // random full + partial writes, then read back
    for (int it = 0; it < 6; it++) begin
      u  = $urandom_range(0, 1);
      a  = 16'($urandom_range(64, 127)) << 2;
      wd = $urandom;
      st = 4'($urandom_range(1, 15));
      do_req(u, 1'b1, a, $urandom, 4'hF);
      do_req(u, 1'b1, a, wd, st);
      do_req(u, 1'b0, a, 32'h0, 4'h0);
    end

    // reset mid-op, LATENCY=4
    do_req(2, 1'b1, 16'h0040, 32'hA5A50F0F, 4'hF);
    do_req(2, 1'b0, 16'h0040, 32'h0, 4'h0);
    req_then_reset(2, 1'b0, 16'h0040, 32'h0, 2);
    do_req(2, 1'b0, 16'h0040, 32'h0, 4'h0);
    req_then_reset(2, 1'b1, 16'h0044, 32'h11112222, 1);
    do_req(2, 1'b0, 16'h0044, 32'h0, 4'h0);
    check_eq("reset_write_kept", mem_rdata[2], 32'h11112222);

    // back-to-back pairs around srst
    do_req(0, 1'b1, 16'h0080, 32'h01020304, 4'hF);
    do_req(0, 1'b1, 16'h0084, 32'hF0E0D0C0, 4'hF);
    do_req(0, 1'b0, 16'h0080, 32'h0, 4'h0);
    @(posedge aclk); #1;
    srst = 1'b1;
    @(posedge aclk); #1;
    srst = 1'b0;
    clear_last_rd();
    check_eq("srst_rdata", mem_rdata[0], 32'd0);
    check_eq("srst_ready", 32'(mem_ready[0]), 32'd0);
    do_req(0, 1'b0, 16'h0080, 32'h0, 4'h0);
    do_req(0, 1'b0, 16'h0084, 32'h0, 4'h0);
    check_eq("srst_ram_kept", mem_rdata[0], 32'hF0E0D0C0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/friscv_dmem_responder.md
Name: friscv_dmem_responder

Overview:
- Data-memory responder (slave) on the `mem_*` load/store request interface driven by the core's memory-access unit.
- Holds a word-organised RAM with byte-lane write strobes.
- Answers each request with a single-cycle `mem_ready` pulse after a programmable latency.
- Used as the data RAM in simulation tops and small FPGA builds; also stalls the pipeline realistically.

Parameters:
- ADDRW, 16, byte address width of `mem_addr`.
- XLEN, 32, data width; XLEN/8 byte lanes.
- DEPTH, 1024, RAM size in XLEN words; word index = mem_addr[ADDRW-1:2].
- LATENCY, 1, cycles from request acceptance to `mem_ready`; legal range 1..15.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- srst  in  1  synchronous active-high reset, same effect as aresetn.
- mem_en  in  1  request valid; held high by the initiator until `mem_ready` is sampled.
- mem_wr  in  1  1 = write, 0 = read; stable while mem_en=1.
- mem_addr  in  ADDRW  byte address, word aligned (bits [1:0] ignored).
- mem_wdata  in  XLEN  write data.
- mem_strb  in  XLEN/8  byte-lane write enables; ignored for reads.
- mem_rdata  out  XLEN  read data; valid in the mem_ready cycle.
- mem_ready  out  1  single-cycle completion pulse.

Behaviour:
- Reset:
  - The single clock is `aclk`; reset is asynchronous and active-low on `aresetn` (fixed).
  - aresetn=0 or srst=1: state=IDLE, counter=0, mem_ready=0, mem_rdata=0.
  - RAM contents are not reset.
- State machine:
  - IDLE: when mem_en=1, the request is accepted at this edge.
    - Write: each lane i with mem_strb[i]=1 commits mem_wdata byte i to word `idx`.
    - Read: word `idx` is captured into the read register; mem_rdata takes it when mem_ready asserts.
    - If LATENCY=1, go to RESP; else go to WAIT with counter=LATENCY-1.
  - WAIT: counter decrements each cycle; on reaching 1, go to RESP.
  - RESP: mem_ready=1 for exactly one cycle, mem_rdata=captured word (last read value for writes); then return to IDLE.
- Latency:
  - mem_en first high in cycle t gives mem_ready high in cycle t+LATENCY.
  - mem_ready is never high on two consecutive cycles.
- Back-to-back:
  - A new mem_en in the cycle after RESP is accepted from IDLE normally; no extra bubble.
  - mem_en is not sampled in WAIT or RESP (the request is already latched).
- Protocol violation: if mem_en drops in WAIT, the block completes anyway. The write has already committed; mem_ready still pulses. No abort path.
- Range:
  - idx >= DEPTH is out of range.
  - Write: dropped, no RAM change.
  - Read: captured value is 0.
  - mem_ready timing is unchanged.
- Read-after-write: a read accepted after a write completes returns the written data (write committed at acceptance).
- mem_rdata holds its value between responses.
- Reset mid-operation: the outstanding request is discarded, with no mem_ready. A write already accepted stays committed.

Optional Feature:
- Macro: FRISCV_DMEM_ERR_EN.
- Defined:
  - Adds output port `mem_err` (1 bit, reset 0).
  - mem_err=1 only in the mem_ready cycle of an out-of-range access; 0 otherwise.
  - Out-of-range read returns 32'hDEADBEEF instead of 0.
- Undefined:
  - No `mem_err` port.
  - Out-of-range accesses complete silently as above.

Test Plan:
- LATENCY=1: write addr 0x0010, wdata 0x12345678, strb 4'hF; then read 0x0010 → mem_ready one cycle after each request; read returns 0x12345678.
- Partial write: preload 0xFFFFFFFF at 0x0020; write wdata 0x000000AB, strb 4'b0001; read → 0xFFFFFFAB.
- LATENCY=3: read request at cycle t → mem_ready high only in cycle t+3, single cycle; mem_en held high throughout.
- Out of range: DEPTH=1024, write then read addr 0x1000 (idx 1024) → RAM unchanged; read 0 (or 0xDEADBEEF with mem_err=1 when FRISCV_DMEM_ERR_EN is defined).
- Reset mid-op: LATENCY=4, aresetn pulsed low 2 cycles after a read request → no mem_ready; mem_rdata=0; next request served normally.
- Back-to-back: two writes then two reads issued with a one-cycle gap each → four mem_ready pulses with correct data; srst=1 for one cycle between pairs clears state but not RAM.
